// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared architecture selector for the Gray-code helper blocks
package lau_pkg;

  typedef enum logic [0:0] {
    FAST = 1'b0,
    SLOW = 1'b1
  } speed_e;

endpackage

// File: rtl/gray_ptr_reader_if.sv
// rtl/gray_ptr_reader_if.sv - read-side FIFO pointer bundle between consumer logic and gray_ptr_reader
interface gray_ptr_reader_if #(
  parameter int width = 4
);

  logic [width-1:0] WPtrGray_i;
  logic             Pop_i;
  logic             ErrClr_i;
  logic             PopAck_o;
  logic [width-1:0] RPtrGray_o;
  logic [width-1:0] RPtrBin_o;
  logic [width-1:0] Fill_o;
  logic             Empty_o;
  logic             StepErr_o;
  logic             OvfErr_o;

  modport master (
    output WPtrGray_i, Pop_i, ErrClr_i,
    input  PopAck_o, RPtrGray_o, RPtrBin_o, Fill_o, Empty_o, StepErr_o, OvfErr_o
  );

  modport slave (
    input  WPtrGray_i, Pop_i, ErrClr_i,
    output PopAck_o, RPtrGray_o, RPtrBin_o, Fill_o, Empty_o, StepErr_o, OvfErr_o
  );

endinterface

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchronizer chain for a Gray-coded bus
module gray_sync #(
  parameter int width  = 4,
  parameter int stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [stages-1:0][width-1:0] r_chain;

  // Only Gray-coded values may cross here, so per-bit metastability resolves to old or new.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[stages-2:0], i_d};
    end
  end

  assign o_q = r_chain[stages-1];

endmodule

// File: rtl/lau_bin2gray.sv
// rtl/lau_bin2gray.sv - binary to Gray converter
module lau_bin2gray #(
  parameter int width = 4
) (
  input  logic [width-1:0] i_bin,
  output logic [width-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/lau_gray2bin.sv
// rtl/lau_gray2bin.sv - Gray to binary converter, parallel (FAST) or ripple (SLOW) form
module lau_gray2bin
  import lau_pkg::*;
#(
  parameter int     width = 4,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] i_gray,
  output logic [width-1:0] o_bin
);

  generate
    if (speed == FAST) begin : g_fast
      always_comb begin
        o_bin = '0;
        for (int i = 0; i < width; i++) begin
          o_bin[i] = ^(i_gray >> i);
        end
      end
    end else begin : g_slow
      logic w_acc;
      always_comb begin
        o_bin = '0;
        w_acc = 1'b0;
        for (int i = width - 1; i >= 0; i--) begin
          w_acc    = w_acc ^ i_gray[i];
          o_bin[i] = w_acc;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/lau_gray_inc.sv
// rtl/lau_gray_inc.sv - Gray code incrementer (decode, add one, re-encode)
module lau_gray_inc
  import lau_pkg::*;
#(
  parameter int     width = 4,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] i_gray,
  output logic [width-1:0] o_gray
);

  logic [width-1:0] w_bin;
  logic [width-1:0] w_bin_inc;

  lau_gray2bin #(.width(width), .speed(speed)) u_dec (
    .i_gray (i_gray),
    .o_bin  (w_bin)
  );

  assign w_bin_inc = w_bin + width'(1);

  lau_bin2gray #(.width(width)) u_enc (
    .i_bin  (w_bin_inc),
    .o_gray (o_gray)
  );

endmodule

// File: rtl/gray_ptr_reader.sv
// rtl/gray_ptr_reader.sv - async FIFO read-side pointer, fill/empty and write-pointer sanity checks
module gray_ptr_reader
  import lau_pkg::*;
#(
  parameter int     width      = 4,
  parameter int     syncStages = 2,
  parameter speed_e speed      = FAST
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  gray_ptr_reader_if.slave  bus
);

  localparam int               DepthInt = 2 ** (width - 1);
  localparam logic [width-1:0] Depth    = DepthInt[width-1:0];

  logic [width-1:0] w_wgray_sync;
  logic [width-1:0] w_wbin_sync;
  logic [width-1:0] w_rgray_inc;
  logic [width-1:0] w_rbin;
  logic [width-1:0] w_fill;
  logic             w_empty;
  logic             w_pop_ack;
  logic             w_step_bad;
  logic             w_ovf_bad;

  logic [width-1:0] r_wgray_q;
  logic [width-1:0] r_wbin_q;
  logic [width-1:0] r_rgray_q;
  logic             r_step_err;
  logic             r_ovf_err;

  gray_sync #(.width(width), .stages(syncStages)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (bus.WPtrGray_i),
    .o_q    (w_wgray_sync)
  );

  lau_gray2bin #(.width(width), .speed(speed)) u_wdec (
    .i_gray (w_wgray_sync),
    .o_bin  (w_wbin_sync)
  );

  lau_gray2bin #(.width(width), .speed(speed)) u_rdec (
    .i_gray (r_rgray_q),
    .o_bin  (w_rbin)
  );

  lau_gray_inc #(.width(width), .speed(speed)) u_rinc (
    .i_gray (r_rgray_q),
    .o_gray (w_rgray_inc)
  );

  // Modular subtraction; the wrap bit keeps full (Depth) distinct from empty (0).
  assign w_fill     = r_wbin_q - w_rbin;
  assign w_empty    = (w_fill == '0);
  assign w_pop_ack  = bus.Pop_i & ~w_empty;
  assign w_step_bad = ($countones(w_wgray_sync ^ r_wgray_q) > 1);
  assign w_ovf_bad  = (w_fill > Depth);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wgray_q  <= '0;
      r_wbin_q   <= '0;
      r_rgray_q  <= '0;
      r_step_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_wgray_q  <= w_wgray_sync;
      r_wbin_q   <= w_wbin_sync;
      if (w_pop_ack) begin
        r_rgray_q <= w_rgray_inc;
      end
      // A fresh error in the clear cycle takes priority over the clear.
      r_step_err <= w_step_bad | (r_step_err & ~bus.ErrClr_i);
      r_ovf_err  <= w_ovf_bad  | (r_ovf_err  & ~bus.ErrClr_i);
    end
  end

  assign bus.PopAck_o   = w_pop_ack;
  assign bus.RPtrGray_o = r_rgray_q;
  assign bus.RPtrBin_o  = w_rbin;
  assign bus.Fill_o     = w_fill;
  assign bus.Empty_o    = w_empty;
  assign bus.StepErr_o  = r_step_err;
  assign bus.OvfErr_o   = r_ovf_err;

endmodule

// File: tb/tb_gray_ptr_reader.sv
// tb/tb_gray_ptr_reader.sv - self-checking bench for gray_ptr_reader against a count-based model
module tb_gray_ptr_reader;
  import lau_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_ptr_reader_if #(.width(4)) bus ();

  gray_ptr_reader #(.width(4), .syncStages(2), .speed(FAST)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: write and read positions as plain integer counts; hist[k] is the write count k edges ago.
  int w;
  int rcnt;
  int hist[$];
  bit step_m, ovf_m;
  bit pop, clr;

  function automatic int g(int x);
    x = x & 15;
    return x ^ (x >> 1);
  endfunction

  function automatic int nbits(int x);
    int c = 0;
    for (int i = 0; i < 4; i++) c += (x >> i) & 1;
    return c;
  endfunction

  function automatic int fill_m();
    return (hist[2] - rcnt) & 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.WPtrGray_i = 4'(g(w));
    bus.Pop_i      = pop;
    bus.ErrClr_i   = clr;
  endtask

  task automatic cycle();
    int  f;
    bit  ack, c_step, c_ovf;
    drive();
    #1;
    f   = fill_m();
    ack = pop && (f != 0);
    check("fill",    bus.Fill_o,     f);
    check("empty",   bus.Empty_o,    (f == 0));
    check("popack",  bus.PopAck_o,   ack);
    check("rgray",   bus.RPtrGray_o, g(rcnt));
    check("rbin",    bus.RPtrBin_o,  rcnt & 15);
    check("steperr", bus.StepErr_o,  step_m);
    check("ovferr",  bus.OvfErr_o,   ovf_m);
    c_step = nbits(g(hist[1]) ^ g(hist[2])) > 1;
    c_ovf  = f > 8;
    @(posedge clk);
    step_m = c_step | (step_m & !clr);
    ovf_m  = c_ovf  | (ovf_m  & !clr);
    if (ack) rcnt++;
    hist.push_front(w);
    void'(hist.pop_back());
    @(negedge clk);
  endtask

  // Asserts reset asynchronously mid-cycle, checks outputs at once, then releases on a later negedge.
  task automatic do_reset(input int w0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_rgray", bus.RPtrGray_o, 0);
    check("rst_rbin",  bus.RPtrBin_o,  0);
    check("rst_fill",  bus.Fill_o,     0);
    check("rst_empty", bus.Empty_o,    1);
    check("rst_ack",   bus.PopAck_o,   0);
    check("rst_step",  bus.StepErr_o,  0);
    check("rst_ovf",   bus.OvfErr_o,   0);
    hist = '{0, 0, 0, 0};
    rcnt = 0;
    step_m = 0;
    ovf_m = 0;
    pop = 0;
    clr = 0;
    w = w0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    w = 0; pop = 0; clr = 0;
    hist = '{0, 0, 0, 0};
    drive();
    @(negedge clk);

    // Reset with Gray 0110 held; fill reaches 4 three edges after release.
    do_reset(4);
    repeat (3) cycle();
    check("t1_fill", bus.Fill_o, 4);

    // Single-bit steps 0000 -> 0001 -> 0011.
    do_reset(0);
    w = 1;
    repeat (4) cycle();
    check("t2_fill1", bus.Fill_o, 1);
    w = 2;
    repeat (4) cycle();
    check("t2_fill2", bus.Fill_o, 2);
    check("t2_step", bus.StepErr_o, 0);

    // Pop held for four cycles with two entries.
    pop = 1;
    repeat (4) cycle();
    pop = 0;
    check("t3_empty", bus.Empty_o, 1);
    check("t3_rgray", bus.RPtrGray_o, 4'b0011);

    // Full wrap of both pointers.
    do_reset(0);
    for (int i = 0; i < 16; i++) begin
      w++;
      repeat (3) cycle();
      pop = 1;
      cycle();
      pop = 0;
    end
    check("t4_rgray", bus.RPtrGray_o, 0);
    check("t4_step",  bus.StepErr_o, 0);
    check("t4_ovf",   bus.OvfErr_o, 0);

    // Multi-bit jump sets the sticky step error; clear, then clear colliding with a new error.
    do_reset(0);
    w = 2;
    repeat (4) cycle();
    check("t5_step_set", bus.StepErr_o, 1);
    clr = 1;
    cycle();
    clr = 0;
    cycle();
    check("t5_step_clr", bus.StepErr_o, 0);
    w = 7;
    repeat (2) cycle();
    clr = 1;
    cycle();
    clr = 0;
    cycle();
    check("t5_step_win", bus.StepErr_o, 1);

    // Overflow with Gray(9), then reset in the middle of an accepted pop.
    do_reset(0);
    w = 9;
    repeat (5) cycle();
    check("t6_fill", bus.Fill_o, 9);
    check("t6_ovf",  bus.OvfErr_o, 1);
    pop = 1;
    drive();
    #1;
    check("t6_ack", bus.PopAck_o, 1);
    do_reset(0);

    // Randomized legal traffic with occasional two-step jumps and error clears.
    for (int n = 0; n < 2000; n++) begin
      int r;
      pop = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 31) == 0);
      r = $urandom_range(0, 39);
      if (w - rcnt < 9) begin
        if (r == 0) w += 2;
        else if (r < 20) w += 1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_ptr_reader.md
Name: gray_ptr_reader

Overview:
- Read-side pointer logic for an asynchronous FIFO. It pairs with a write-side Gray counter built on the Gray incrementer.
- Brings in the foreign Gray write pointer through a synchronizer and decodes it to binary. It also checks that the pointer moves by at most one Gray step.
- Maintains the local read pointer in Gray form and computes fill and empty. It returns a glitch-free registered Gray read pointer for the write side.

Parameters:
- width, 4, pointer width in bits including the wrap bit; FIFO depth = 2^(width-1).
- syncStages, 2, number of synchronizer flops on WPtrGray_i; must be >= 2.
- speed, lau_pkg::FAST, architecture selector passed to the Gray incrementer and Gray-to-binary sub-blocks.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- WPtrGray_i  in  width  Gray write pointer from the foreign clock domain.
- Pop_i  in  1  read request.
- ErrClr_i  in  1  clears the sticky error flags.
- PopAck_o  out  1  pop accepted this cycle; combinational = Pop_i & ~Empty_o.
- RPtrGray_o  out  width  registered Gray read pointer, sent to the write domain.
- RPtrBin_o  out  width  binary read pointer, used as the RAM read address.
- Fill_o  out  width  number of entries available.
- Empty_o  out  1  Fill_o == 0.
- StepErr_o  out  1  sticky: synchronized write pointer changed by more than one bit.
- OvfErr_o  out  1  sticky: Fill_o exceeded the depth 2^(width-1).

Behaviour:
- Reset: one clock, clk_i. Reset is asynchronous, active-low (rst_ni), and clears every flop to 0: sync chain, WGrayQ, WBinQ, RGrayQ, and both error flags. After reset: RPtrGray_o=0, RPtrBin_o=0, Fill_o=0, Empty_o=1, StepErr_o=0, OvfErr_o=0.
- Reset asserted mid-operation also clears all state immediately. No partial pop completes.
- Sync: WPtrGray_i passes through syncStages flops. The last stage feeds WGrayQ, the previous-value register used for the step check.
- Decode: WBinQ <= Gray2Bin(sync output), registered. Latency from a WPtrGray_i change to a Fill_o update is syncStages+1 edges.
- Step check: every cycle, if popcount(sync output ^ WGrayQ) > 1, StepErr_o sets on the next edge. A change of zero bits or exactly one bit is legal, including wrap from 10..0 to 0..0.
- Read pointer: RGrayQ holds the pointer in Gray code. A pop is accepted when Pop_i=1 and Empty_o=0. On accept, RGrayQ <= IncGray(RGrayQ) at the next edge.
- Pop when empty is ignored: PopAck_o=0 and no state changes.
- RPtrBin_o = Gray2Bin(RGrayQ), combinational from the register. RPtrGray_o = RGrayQ, driven directly by the flop with no logic after it.
- Fill_o = (WBinQ - RPtrBin_o) mod 2^width. Fill and Empty reflect the pop in the cycle after PopAck_o.
- OvfErr_o sets on the next edge when Fill_o > 2^(width-1).
- Pointer wrap: all pointers wrap modulo 2^width. The wrap bit distinguishes full from empty, so Fill_o = 2^(width-1) is legal (full).
- Simultaneous events:
  - A write-pointer update and a pop in the same cycle are independent. Fill is recomputed from both new values.
  - ErrClr_i together with a new error condition in the same cycle: the error wins and the flag stays 1.

Decomposition:
- lau_pkg: reuse speed_e. Add no new typedefs.
- Reuse the existing Gray incrementer, Gray-to-binary converter and binary-to-Gray converter as-is.
- One natural new sub-module: gray_sync, a parameterized syncStages flop chain with async active-low reset.

Test Plan:
- Reset with width=4 and WPtrGray_i=0110 held -> after reset Fill_o=0, Empty_o=1, RPtrGray_o=0000. Three edges after release Fill_o=4 (Gray 0110 = binary 4).
- WPtrGray_i steps 0000→0001→0011 -> Fill_o goes 1, then 2, each syncStages+1 edges after its input change. StepErr_o stays 0.
- Fill=2, then Pop_i held 4 cycles -> PopAck_o high 2 cycles. RPtrGray_o goes 0001, then 0011, then stops. Empty_o=1 and no further change.
- Wrap: drive a write sequence of 16 Gray steps and pop after each one -> RPtrGray_o returns to 0000 after 1000. No errors.
- WPtrGray_i jumps 0000→0011 -> StepErr_o=1 and stays 1. ErrClr_i pulse clears it. Repeat with ErrClr_i asserted in the same cycle as the jump -> flag stays 1.
- WPtrGray_i = Gray(9) with RPtr=0 -> Fill_o=9 > 8, so OvfErr_o=1. Asserting rst_ni low mid-pop -> all outputs return to their reset values immediately.
